avalon_protocol_checker: RTL and testbench
==========================================

AVALON_PROTOCOL_CHECKER -- requirements
Module: avalon_protocol_checker

Interface
REQ-001 SHALL have parameter AVALONMODE, default 0; 0=waitrequest, 1=fixed wait, 2=pipelined variable, 3=pipelined fixed, 4=burst.
REQ-002 SHALL have parameter NBDATABYTES, default 2; data width is 8*NBDATABYTES, byteenable width is NBDATABYTES.
REQ-003 SHALL have parameter NBADDRBITS, default 8; address width.
REQ-004 SHALL have parameters WRITEDELAY, default 2, and READDELAY, default 1; command hold cycles in mode 1, each >=1.
REQ-005 SHALL have parameter FIXEDDELAY, default 2; read latency in cycles for mode 3, >=1.
REQ-006 SHALL have parameter MAXPENDING, default 16; max outstanding read words, >=1.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 Avalon inputs: address (NBADDRBITS), byteenable (NBDATABYTES), readdata and writedata (8*NBDATABYTES), read, write, waitrequest, readdatavalid, burstcount (8), beginbursttransfer (1 each unless stated).
REQ-010 err_flags  out  6  sticky error bits E0..E5.
REQ-011 err_pulse  out  1  high for the cycle after any new error is detected.
REQ-012 first_err  out  3  index of the first error since reset; 7 when none.
REQ-013 pending  out  $clog2(MAXPENDING+1)  outstanding read words.
REQ-014 nb_reads, nb_writes  out  32 each  accepted command counters, see Configuration.

Function
REQ-015 Command accept: in modes 0, 2 and 4, accept = (read|write) & !waitrequest; in mode 3, accept = read|write.
REQ-016 Mode 1: an internal hold counter SHALL count consecutive cycles of an unchanged command; accept occurs in the cycle the count reaches READDELAY for reads or WRITEDELAY for writes; the counter clears on accept.
REQ-017 E0 SHALL be raised when read & write are both high in any cycle.
REQ-018 E1 SHALL be raised in modes 0, 2 and 4 when the previous cycle was (read|write) & waitrequest and any of read, write, address, byteenable, writedata or burstcount differs in the current cycle.
REQ-019 E1 SHALL also be raised in mode 1 when the command changes before the hold count is reached.
REQ-020 pending SHALL update as pending + added - (readdatavalid ? 1 : 0), where added = 1 for an accepted read (burstcount for an accepted read in mode 4) and 0 otherwise; accept and readdatavalid in the same cycle are handled in one update.
REQ-021 E2 SHALL be raised in modes 2, 3 and 4 when readdatavalid is high while pending = 0 and no read is accepted in that cycle; pending then stays at 0.
REQ-022 E3 SHALL be raised when pending + added would exceed MAXPENDING; pending then saturates at MAXPENDING.
REQ-023 E4, mode 3 only: a FIXEDDELAY-deep shift register SHALL track accepted reads; E4 is raised when readdatavalid differs from the shift register output.
REQ-024 Mode 4 FSM, state IDLE: accepted write with burstcount N>1 -> WBURST with remaining = N-1; accepted write with N=1 stays in IDLE.
REQ-025 Mode 4 FSM, state WBURST: each accepted write decrements remaining; at remaining = 1 the accepted write returns the FSM to IDLE.
REQ-026 E5, mode 4 only, SHALL be raised on any of:
- burstcount = 0 on an accepted command;
- beginbursttransfer without read|write;
- beginbursttransfer or an accepted read while in WBURST.
REQ-027 On E5 the FSM SHALL return to IDLE.
REQ-028 Within one cycle, all applicable errors SHALL be flagged together; when several are new, first_err records the lowest index.
REQ-029 A flag already set SHALL NOT retrigger err_pulse.
REQ-030 The checker SHALL be purely observational: no output drives the bus.

Reset
REQ-031 While rst is high the block SHALL set err_flags = 0, err_pulse = 0, first_err = 7, pending = 0, nb_reads = 0 and nb_writes = 0, and clear the FSM to IDLE, the hold counter, the shift register and the stall-capture registers.
REQ-032 A reset asserted mid-burst or with reads outstanding SHALL discard that context; readdatavalid arriving after reset SHALL raise E2.

Configuration
REQ-033 Macro AVALON_PROTOCOL_CHECKER_COUNTERS_EN defined: nb_reads and nb_writes SHALL increment on each accepted read and accepted write respectively, saturating at 2^32-1.
REQ-034 Macro AVALON_PROTOCOL_CHECKER_COUNTERS_EN undefined: nb_reads and nb_writes SHALL be constant 0 and the counter logic SHALL NOT be present.

Verification
REQ-035 Mode 0: read with waitrequest=1 for 3 cycles, address held at 0x12 -> err_flags=0 and pending becomes 1 after accept.
REQ-036 Mode 0: address changes 0x12->0x13 while waitrequest=1 -> err_flags[1]=1, err_pulse high one cycle, first_err=1.
REQ-037 Mode 3, FIXEDDELAY=2: read accepted at cycle 10, readdatavalid at cycle 12 -> no error; readdatavalid at cycle 13 instead -> E4 set.
REQ-038 Mode 2, MAXPENDING=2: 3 reads accepted back-to-back with no readdatavalid -> E3 set, pending=2; then 3 readdatavalid pulses -> pending=0 and E2 set.
REQ-039 Mode 4: write burst with burstcount=4, read accepted after beat 2 -> E5 set, FSM back in IDLE; rst pulse -> err_flags=0, first_err=7.
REQ-040 With the counters macro defined: 5 reads and 3 writes accepted -> nb_reads=5, nb_writes=3; with it undefined -> both outputs 0.

Source files
------------

// File: rtl/avalon_protocol_checker.sv
// Passive Avalon-MM protocol checker: sticky error flags E0..E5, outstanding-read tracking, burst FSM.
// Define AVALON_PROTOCOL_CHECKER_COUNTERS_EN to enable the saturating nb_reads/nb_writes counters.
module avalon_protocol_checker #(
  parameter int AVALONMODE  = 0,
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WRITEDELAY  = 2,
  parameter int READDELAY   = 1,
  parameter int FIXEDDELAY  = 2,
  parameter int MAXPENDING  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NBADDRBITS-1:0]            address,
  input  logic [NBDATABYTES-1:0]           byteenable,
  input  logic [8*NBDATABYTES-1:0]         readdata,
  input  logic [8*NBDATABYTES-1:0]         writedata,
  input  logic                             read,
  input  logic                             write,
  input  logic                             waitrequest,
  input  logic                             readdatavalid,
  input  logic [7:0]                       burstcount,
  input  logic                             beginbursttransfer,
  output logic [5:0]                       err_flags,
  output logic                             err_pulse,
  output logic [2:0]                       first_err,
  output logic [$clog2(MAXPENDING+1)-1:0]  pending,
  output logic [31:0]                      nb_reads,
  output logic [31:0]                      nb_writes
);

  localparam int DW   = 8*NBDATABYTES;
  localparam int MAXD = (WRITEDELAY > READDELAY) ? WRITEDELAY : READDELAY;
  localparam int HW   = $clog2(MAXD+1);
  localparam int PW   = $clog2(MAXPENDING+1);

  typedef enum logic {IDLE, WBURST} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             remaining_q, remaining_d;
  logic                   stall_q, stall_d;
  logic                   cap_read_q, cap_write_q;
  logic [NBADDRBITS-1:0]  cap_address_q;
  logic [NBDATABYTES-1:0] cap_byteenable_q;
  logic [DW-1:0]          cap_writedata_q;
  logic [7:0]             cap_burstcount_q;
  logic [HW-1:0]          hold_q, hold_d, hold_cur;
  logic [PW-1:0]          pending_q, pending_d;
  logic [FIXEDDELAY-1:0]  sr_q, sr_d;
  logic [5:0]             err_flags_q, err_flags_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [2:0]             first_err_q, first_err_d;

  logic       cmd, cmd_changed, delay_hit, accept, read_acc, write_acc, e5;
  logic [8:0] added;
  logic [31:0] sum, pend_next;
  logic [5:0] new_err, fresh;

  logic unused_readdata;
  assign unused_readdata = ^readdata;

  // Command acceptance, including the mode-1 hold counter of an unchanged command
  always_comb begin
    cmd = read | write;
    cmd_changed = (read != cap_read_q) || (write != cap_write_q) ||
                  (address != cap_address_q) || (byteenable != cap_byteenable_q) ||
                  (writedata != cap_writedata_q) || (burstcount != cap_burstcount_q);
    hold_cur = '0;
    if (cmd)
      hold_cur = ((hold_q != '0) && !cmd_changed) ? hold_q + 1'b1 : HW'(1);
    delay_hit = read ? (hold_cur == HW'(READDELAY)) : (hold_cur == HW'(WRITEDELAY));
    case (AVALONMODE)
      1:       accept = cmd & delay_hit;
      3:       accept = cmd;
      default: accept = cmd & ~waitrequest;
    endcase
    read_acc  = accept & read;
    write_acc = accept & write;
    hold_d    = ((AVALONMODE == 1) && !accept) ? hold_cur : '0;
    stall_d   = cmd & waitrequest;
  end

  // Outstanding reads: the add and the readdatavalid retire happen in one update
  always_comb begin
    added = '0;
    if (read_acc)
      added = (AVALONMODE == 4) ? {1'b0, burstcount} : 9'd1;
    sum = 32'(pending_q) + 32'(added);
    pend_next = (readdatavalid && (sum != 32'd0)) ? sum - 32'd1 : sum;
    if (pend_next > 32'(MAXPENDING))
      pend_next = 32'(MAXPENDING);
    pending_d = PW'(pend_next);
    sr_d[0] = read_acc;
    for (int i = 1; i < FIXEDDELAY; i++)
      sr_d[i] = sr_q[i-1];
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    e5          = 1'b0;
    if (AVALONMODE == 4) begin
      if (accept && (burstcount == 8'd0))
        e5 = 1'b1;
      if (beginbursttransfer && !cmd)
        e5 = 1'b1;
      if ((state_q == WBURST) && (beginbursttransfer || read_acc))
        e5 = 1'b1;
      case (state_q)
        IDLE: begin
          if (write_acc && (burstcount > 8'd1)) begin
            state_d     = WBURST;
            remaining_d = burstcount - 8'd1;
          end
        end
        WBURST: begin
          if (write_acc) begin
            if (remaining_q == 8'd1)
              state_d = IDLE;
            else
              remaining_d = remaining_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (e5)
        state_d = IDLE;
    end
  end

  // Error collection; the lowest newly raised index wins first_err
  always_comb begin
    new_err    = '0;
    new_err[0] = read & write;
    if (AVALONMODE == 1)
      new_err[1] = (hold_q != '0) && cmd_changed;
    else if (AVALONMODE != 3)
      new_err[1] = stall_q && cmd_changed;
    new_err[2] = ((AVALONMODE == 2) || (AVALONMODE == 3) || (AVALONMODE == 4)) &&
                 readdatavalid && (pending_q == '0) && !read_acc;
    new_err[3] = sum > 32'(MAXPENDING);
    new_err[4] = (AVALONMODE == 3) && (readdatavalid != sr_q[FIXEDDELAY-1]);
    new_err[5] = e5;
    fresh       = new_err & ~err_flags_q;
    err_flags_d = err_flags_q | new_err;
    err_pulse_d = |fresh;
    first_err_d = first_err_q;
    if (first_err_q == 3'd7) begin
      for (int i = 5; i >= 0; i--)
        if (fresh[i])
          first_err_d = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      remaining_q      <= '0;
      stall_q          <= 1'b0;
      cap_read_q       <= 1'b0;
      cap_write_q      <= 1'b0;
      cap_address_q    <= '0;
      cap_byteenable_q <= '0;
      cap_writedata_q  <= '0;
      cap_burstcount_q <= '0;
      hold_q           <= '0;
      pending_q        <= '0;
      sr_q             <= '0;
      err_flags_q      <= '0;
      err_pulse_q      <= 1'b0;
      first_err_q      <= 3'd7;
    end else begin
      state_q          <= state_d;
      remaining_q      <= remaining_d;
      stall_q          <= stall_d;
      cap_read_q       <= read;
      cap_write_q      <= write;
      cap_address_q    <= address;
      cap_byteenable_q <= byteenable;
      cap_writedata_q  <= writedata;
      cap_burstcount_q <= burstcount;
      hold_q           <= hold_d;
      pending_q        <= pending_d;
      sr_q             <= sr_d;
      err_flags_q      <= err_flags_d;
      err_pulse_q      <= err_pulse_d;
      first_err_q      <= first_err_d;
    end
  end

  assign err_flags = err_flags_q;
  assign err_pulse = err_pulse_q;
  assign first_err = first_err_q;
  assign pending   = pending_q;

`ifdef AVALON_PROTOCOL_CHECKER_COUNTERS_EN
  logic [31:0] nb_reads_q, nb_reads_d, nb_writes_q, nb_writes_d;

  always_comb begin
    nb_reads_d  = nb_reads_q;
    nb_writes_d = nb_writes_q;
    if (read_acc && (nb_reads_q != 32'hFFFF_FFFF))
      nb_reads_d = nb_reads_q + 32'd1;
    if (write_acc && (nb_writes_q != 32'hFFFF_FFFF))
      nb_writes_d = nb_writes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nb_reads_q  <= '0;
      nb_writes_q <= '0;
    end else begin
      nb_reads_q  <= nb_reads_d;
      nb_writes_q <= nb_writes_d;
    end
  end

  assign nb_reads  = nb_reads_q;
  assign nb_writes = nb_writes_q;
`else
  assign nb_reads  = '0;
  assign nb_writes = '0;
`endif

endmodule

// File: tb/tb_avalon_protocol_checker.sv
// Directed bench: one checker per Avalon mode on a shared bus; mode 0 is table driven.
module tb_avalon_protocol_checker;

  typedef struct {
    logic       rst;
    logic       rd;
    logic       wr;
    logic       wt;
    logic [7:0] addr;
    logic       rdv;
    logic [5:0] flags;
    logic       pulse;
    logic [2:0] first;
    logic [4:0] pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [1:0]  byteenable;
  logic [15:0] readdata, writedata;
  logic        read, write, waitrequest, readdatavalid;
  logic [7:0]  burstcount;
  logic        beginbursttransfer;

  logic [4:0][5:0]  flags;
  logic [4:0]       pulse;
  logic [4:0][2:0]  first;
  logic [4:0][4:0]  pend;
  logic [1:0]       pend2;
  logic [4:0][31:0] nr, nw;

  int checks = 0;
  int errors = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  avalon_protocol_checker #(.AVALONMODE(0)) u0 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .err_flags(flags[0]), .err_pulse(pulse[0]), .first_err(first[0]), .pending(pend[0]),
    .nb_reads(nr[0]), .nb_writes(nw[0]));

  avalon_protocol_checker #(.AVALONMODE(1), .WRITEDELAY(2), .READDELAY(1)) u1 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .err_flags(flags[1]), .err_pulse(pulse[1]), .first_err(first[1]), .pending(pend[1]),
    .nb_reads(nr[1]), .nb_writes(nw[1]));

  avalon_protocol_checker #(.AVALONMODE(2), .MAXPENDING(2)) u2 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .err_flags(flags[2]), .err_pulse(pulse[2]), .first_err(first[2]), .pending(pend2),
    .nb_reads(nr[2]), .nb_writes(nw[2]));

  avalon_protocol_checker #(.AVALONMODE(3), .FIXEDDELAY(2)) u3 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .err_flags(flags[3]), .err_pulse(pulse[3]), .first_err(first[3]), .pending(pend[3]),
    .nb_reads(nr[3]), .nb_writes(nw[3]));

  avalon_protocol_checker #(.AVALONMODE(4)) u4 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .err_flags(flags[4]), .err_pulse(pulse[4]), .first_err(first[4]), .pending(pend[4]),
    .nb_reads(nr[4]), .nb_writes(nw[4]));

  assign pend[2] = {3'b000, pend2};

  // Drive one cycle of bus activity, then let it be sampled and settle past the edge
  task automatic applyStimulus(input logic r, input logic rd, input logic wr, input logic wt,
                               input logic [7:0] addr, input logic rdv,
                               input logic [7:0] bc, input logic bbt);
    rst                = r;
    read               = rd;
    write              = wr;
    waitrequest        = wt;
    address            = addr;
    readdatavalid      = rdv;
    burstcount         = bc;
    beginbursttransfer = bbt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    byteenable = 2'b11;
    writedata  = 16'hA5A5;
    readdata   = 16'h0000;

    //            rst   rd    wr    wt    addr   rdv   flags  pulse first pend
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 6'h00, 1'b0, 3'd7, 5'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 6'h02, 1'b1, 3'd1, 5'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0, 6'h02, 1'b0, 3'd1, 5'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 6'h03, 1'b1, 3'd1, 5'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0, 6'h03, 1'b0, 3'd1, 5'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 3'd7, 5'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 6'h01, 1'b1, 3'd0, 5'd0};

    $display("[TB] mode 0 vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].wt, vecs[i].addr, vecs[i].rdv, 8'd1, 1'b0);
      checkOutput($sformatf("m0 v%0d flags", i), 32'(flags[0]), 32'(vecs[i].flags));
      checkOutput($sformatf("m0 v%0d pulse", i), 32'(pulse[0]), 32'(vecs[i].pulse));
      checkOutput($sformatf("m0 v%0d first", i), 32'(first[0]), 32'(vecs[i].first));
      checkOutput($sformatf("m0 v%0d pending", i), 32'(pend[0]), 32'(vecs[i].pend));
    end

    $display("[TB] mode 1 hold counter");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    applyStimulus(0, 0, 1, 0, 8'h05, 0, 8'd1, 0);
    checkOutput("m1 hold1 flags", 32'(flags[1]), 32'h00);
    applyStimulus(0, 0, 1, 0, 8'h05, 0, 8'd1, 0);
    applyStimulus(0, 0, 1, 0, 8'h06, 0, 8'd1, 0);
    checkOutput("m1 after accept flags", 32'(flags[1]), 32'h00);
    applyStimulus(0, 0, 0, 0, 8'h06, 0, 8'd1, 0);
    checkOutput("m1 early drop flags", 32'(flags[1]), 32'h02);
    checkOutput("m1 early drop first", 32'(first[1]), 32'd1);
    applyStimulus(0, 1, 0, 0, 8'h06, 0, 8'd1, 0);
    checkOutput("m1 read pending", 32'(pend[1]), 32'd1);

    $display("[TB] mode 3 fixed latency");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    applyStimulus(0, 1, 0, 0, 8'h20, 0, 8'd1, 0);
    checkOutput("m3 read pending", 32'(pend[3]), 32'd1);
    applyStimulus(0, 0, 0, 0, 8'h20, 0, 8'd1, 0);
    applyStimulus(0, 0, 0, 0, 8'h20, 1, 8'd1, 0);
    checkOutput("m3 on-time flags", 32'(flags[3]), 32'h00);
    checkOutput("m3 on-time pending", 32'(pend[3]), 32'd0);
    applyStimulus(0, 1, 0, 0, 8'h21, 0, 8'd1, 0);
    applyStimulus(0, 0, 0, 0, 8'h21, 0, 8'd1, 0);
    applyStimulus(0, 0, 0, 0, 8'h21, 0, 8'd1, 0);
    checkOutput("m3 late flags", 32'(flags[3]), 32'h10);
    checkOutput("m3 late pulse", 32'(pulse[3]), 32'd1);
    checkOutput("m3 late first", 32'(first[3]), 32'd4);
    applyStimulus(0, 0, 0, 0, 8'h21, 1, 8'd1, 0);
    checkOutput("m3 late rdv pending", 32'(pend[3]), 32'd0);
    checkOutput("m3 late rdv pulse", 32'(pulse[3]), 32'd0);

    $display("[TB] mode 2 overflow and underflow");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    applyStimulus(0, 1, 0, 0, 8'h30, 0, 8'd1, 0);
    checkOutput("m2 pend after 1", 32'(pend2), 32'd1);
    applyStimulus(0, 1, 0, 0, 8'h31, 0, 8'd1, 0);
    checkOutput("m2 flags after 2", 32'(flags[2]), 32'h00);
    applyStimulus(0, 1, 0, 0, 8'h32, 0, 8'd1, 0);
    checkOutput("m2 overflow flags", 32'(flags[2]), 32'h08);
    checkOutput("m2 overflow pending", 32'(pend2), 32'd2);
    checkOutput("m2 overflow first", 32'(first[2]), 32'd3);
    applyStimulus(0, 0, 0, 0, 8'h32, 1, 8'd1, 0);
    checkOutput("m2 rdv1 pending", 32'(pend2), 32'd1);
    applyStimulus(0, 0, 0, 0, 8'h32, 1, 8'd1, 0);
    checkOutput("m2 rdv2 pending", 32'(pend2), 32'd0);
    applyStimulus(0, 0, 0, 0, 8'h32, 1, 8'd1, 0);
    checkOutput("m2 underflow flags", 32'(flags[2]), 32'h0C);
    checkOutput("m2 underflow pending", 32'(pend2), 32'd0);
    checkOutput("m2 underflow pulse", 32'(pulse[2]), 32'd1);

    $display("[TB] mode 4 bursts");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    applyStimulus(0, 0, 1, 0, 8'h40, 0, 8'd2, 1);
    applyStimulus(0, 0, 1, 0, 8'h40, 0, 8'd2, 0);
    applyStimulus(0, 1, 0, 0, 8'h40, 0, 8'd1, 0);
    checkOutput("m4 read after burst flags", 32'(flags[4]), 32'h00);
    checkOutput("m4 read after burst pending", 32'(pend[4]), 32'd1);
    applyStimulus(0, 0, 0, 0, 8'h40, 0, 8'd1, 1);
    checkOutput("m4 lone bbt flags", 32'(flags[4]), 32'h20);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    applyStimulus(0, 0, 1, 0, 8'h50, 0, 8'd4, 1);
    applyStimulus(0, 0, 1, 0, 8'h50, 0, 8'd4, 0);
    applyStimulus(0, 1, 0, 0, 8'h50, 0, 8'd4, 0);
    checkOutput("m4 read in burst flags", 32'(flags[4]), 32'h20);
    checkOutput("m4 read in burst pulse", 32'(pulse[4]), 32'd1);
    checkOutput("m4 read in burst first", 32'(first[4]), 32'd5);
    checkOutput("m4 read in burst pending", 32'(pend[4]), 32'd4);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    checkOutput("m4 reset flags", 32'(flags[4]), 32'h00);
    checkOutput("m4 reset first", 32'(first[4]), 32'd7);
    checkOutput("m4 reset pending", 32'(pend[4]), 32'd0);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'd1, 0);
    checkOutput("m4 rdv after reset flags", 32'(flags[4]), 32'h04);
    checkOutput("m4 rdv after reset first", 32'(first[4]), 32'd2);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'd0, 0);
    checkOutput("m4 bc0 flags", 32'(flags[4]), 32'h24);
    checkOutput("m4 bc0 pulse", 32'(pulse[4]), 32'd1);
    checkOutput("m4 bc0 first", 32'(first[4]), 32'd2);

    $display("[TB] command counters");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'd1, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 0, 0, 8'(i), 0, 8'd1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 0, 8'(i), 0, 8'd1, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8'd1, 0);
`ifdef AVALON_PROTOCOL_CHECKER_COUNTERS_EN
    checkOutput("nb_reads", nr[0], 32'd5);
    checkOutput("nb_writes", nw[0], 32'd3);
`else
    checkOutput("nb_reads", nr[0], 32'd0);
    checkOutput("nb_writes", nw[0], 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
